axis_packet_arbiter: RTL and testbench

//  N-to-1 AXI-Stream arbiter at the ingress of the axis switch. Feeds the axis register pipeline directly downstream.

---
 rtl/axis_switch_pkg.sv | 14 +
 rtl/axis_rr_select.sv | 32 +++
 rtl/axis_packet_arbiter.sv | 138 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the axis switch ingress blocks.
package axis_switch_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Index width for n items, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Round-robin picker: first set bit of req strictly after ptr, wrapping modulo NUM_SLAVES.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a pure function of req and ptr.
module axis_rr_select #(
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_SLAVES-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    logic [2*NUM_SLAVES-1:0] req_dbl;
    int                      pos;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        // Rotating a doubled copy puts ptr+1 at bit 0, so a fixed low-to-high scan gives the wrap order.
        req_dbl = {req, req} >> (int'(ptr) + 1);
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!found && req_dbl[k]) begin
                found = 1'b1;
                pos   = (int'(ptr) + 1 + k) % NUM_SLAVES;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant held from first beat to TLAST, beats tagged with source on m_id.
// Latency: one arbitration cycle from IDLE, back-to-back grants at end of packet; data path is combinational.
// Backpressure: m_ready goes straight to the granted port's s_ready; all other ports see s_ready low.
module axis_packet_arbiter
    import axis_switch_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 2,
    parameter int HAS_DEST   = 1,
    parameter int HAS_LAST   = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_SLAVES-1:0]            s_valid,
    output logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SLAVES*DEST_WIDTH-1:0] s_dest,
    input  logic [NUM_SLAVES-1:0]            s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic                             m_last
);

    localparam int IDX_W = clog2_min1(NUM_SLAVES);

    generate
        if (NUM_SLAVES < 2 || NUM_SLAVES > 16) begin : g_bad_num
            $error("axis_packet_arbiter: NUM_SLAVES must be in 2..16");
        end
        if (ID_WIDTH < IDX_W) begin : g_bad_id
            $error("axis_packet_arbiter: ID_WIDTH too narrow for NUM_SLAVES");
        end
    endgenerate

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [DATA_WIDTH-1:0]  data_arr [NUM_SLAVES];
    logic [DEST_WIDTH-1:0]  dest_arr [NUM_SLAVES];

    logic                   idle_found, eop_found;
    logic [IDX_W-1:0]       idle_idx, eop_idx;
    logic [NUM_SLAVES-1:0]  eop_req;
    logic                   active;
    logic                   g_valid;
    logic                   eop;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_unpack
        assign data_arr[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign dest_arr[i] = s_dest[i*DEST_WIDTH +: DEST_WIDTH];
    end

    // Outputs are forced quiet during reset even before the state register has cleared.
    assign active  = aresetn && (state_q == ARB_LOCKED);
    assign g_valid = s_valid[grant_q];
    assign eop     = (HAS_LAST != 0) ? s_last[grant_q] : 1'b1;
    assign eop_req = s_valid & ~(NUM_SLAVES'(1) << grant_q);

    axis_rr_select #(.NUM_SLAVES(NUM_SLAVES), .IDX_W(IDX_W)) u_sel_idle (
        .req   (s_valid),
        .ptr   (rr_ptr_q),
        .found (idle_found),
        .idx   (idle_idx)
    );

    axis_rr_select #(.NUM_SLAVES(NUM_SLAVES), .IDX_W(IDX_W)) u_sel_eop (
        .req   (eop_req),
        .ptr   (grant_q),
        .found (eop_found),
        .idx   (eop_idx)
    );

    always_comb begin
        m_valid = 1'b0;
        s_ready = '0;
        m_data  = '0;
        m_dest  = '0;
        m_id    = '0;
        m_last  = 1'b0;
        if (active) begin
            m_valid              = g_valid;
            s_ready[grant_q]     = m_ready;
            m_data               = data_arr[grant_q];
            m_id[IDX_W-1:0]      = grant_q;
            if (HAS_DEST != 0) begin
                m_dest = dest_arr[grant_q];
            end
            if (HAS_LAST != 0) begin
                m_last = s_last[grant_q];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (idle_found) begin
                    grant_d = idle_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // Hand over only on the final handshake; another waiting port takes the next cycle.
                if (g_valid && m_ready && eop) begin
                    rr_ptr_d = grant_q;
                    if (eop_found) begin
                        grant_d = eop_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_SLAVES - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: vector table for packet sequences plus a HAS_LAST=0 sequence.
module tb_axis_packet_arbiter;

    logic          aclk;
    logic          aresetn;
    logic [3:0]    s_valid;
    logic [255:0]  s_data;
    logic [3:0]    s_dest;
    logic [3:0]    s_last;
    logic          m_ready;

    logic [3:0]    s_ready;
    logic          m_valid;
    logic [63:0]   m_data;
    logic [0:0]    m_dest;
    logic [1:0]    m_id;
    logic          m_last;

    logic [3:0]    nl_s_ready;
    logic          nl_m_valid;
    logic [63:0]   nl_m_data;
    logic [0:0]    nl_m_dest;
    logic [1:0]    nl_m_id;
    logic          nl_m_last;

    int tests_run = 0;
    int tests_failed = 0;

    axis_packet_arbiter dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_dest  (s_dest),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_dest  (m_dest),
        .m_id    (m_id),
        .m_last  (m_last)
    );

    axis_packet_arbiter #(.HAS_LAST(0)) dut_nl (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (nl_s_ready),
        .s_data  (s_data),
        .s_dest  (s_dest),
        .s_last  (s_last),
        .m_valid (nl_m_valid),
        .m_ready (m_ready),
        .m_data  (nl_m_data),
        .m_dest  (nl_m_dest),
        .m_id    (nl_m_id),
        .m_last  (nl_m_last)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int         tst;
        logic       rst_n;
        logic [3:0] vld;
        logic [3:0] last;
        logic       rdy;
        logic       lk;     // arbiter expected LOCKED this cycle
        logic [1:0] id;     // expected grant while locked
        logic       hold;   // m_data must equal previous cycle's
    } vec_t;

    function automatic vec_t mk(int tst, logic rst_n, logic [3:0] vld, logic [3:0] last,
                                logic rdy, logic lk, logic [1:0] id, logic hold);
        vec_t v;
        v.tst = tst; v.rst_n = rst_n; v.vld = vld; v.last = last;
        v.rdy = rdy; v.lk = lk; v.id = id; v.hold = hold;
        return v;
    endfunction

    function automatic logic [63:0] pd(input logic [1:0] p);
        return 64'h0123_4567_89AB_CDEF + {32'(p) * 32'h1111_1111, 32'h0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp, input int idx);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @vec%0d: got %h, expected %h", nm, idx, got, exp);
        end
    endtask

    initial begin
        vec_t        vt[$];
        logic        act;
        logic [1:0]  id;
        logic [3:0]  e_sr;
        logic [63:0] prev_data;
        int          hs4;

        aresetn = 1'b0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b1;
        s_dest  = 4'b1010;
        for (int i = 0; i < 4; i++) s_data[i*64 +: 64] = pd(2'(i));
        prev_data = '0;
        hs4 = 0;

        // 1: single 3-beat packet on port 0
        vt.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 1, 4'b0001, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(1, 1, 4'b0001, 4'b0000, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 4'b0001, 4'b0000, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 4'b0001, 4'b0001, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
        // 2: all ports, one-beat packets, rotation with no bubble
        vt.push_back(mk(2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 0, 0, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 1, 0, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 1, 1, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 1, 2, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 1, 3, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 1, 0, 0));
        vt.push_back(mk(2, 1, 4'b1111, 4'b1111, 1, 1, 1, 0));
        // 3: port 1 4-beat packet, port 2 waits then follows directly
        vt.push_back(mk(3, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(3, 1, 4'b0010, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(3, 1, 4'b0010, 4'b0000, 1, 1, 1, 0));
        vt.push_back(mk(3, 1, 4'b0110, 4'b0000, 1, 1, 1, 0));
        vt.push_back(mk(3, 1, 4'b0110, 4'b0000, 1, 1, 1, 0));
        vt.push_back(mk(3, 1, 4'b0110, 4'b0010, 1, 1, 1, 0));
        vt.push_back(mk(3, 1, 4'b0100, 4'b0100, 1, 1, 2, 0));
        vt.push_back(mk(3, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
        // 4: backpressure and a valid gap on the locked port
        vt.push_back(mk(4, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(4, 1, 4'b0001, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(4, 1, 4'b0001, 4'b0000, 1, 1, 0, 0));
        vt.push_back(mk(4, 1, 4'b0001, 4'b0000, 0, 1, 0, 1));
        vt.push_back(mk(4, 1, 4'b0001, 4'b0000, 0, 1, 0, 1));
        vt.push_back(mk(4, 1, 4'b0001, 4'b0000, 1, 1, 0, 1));
        vt.push_back(mk(4, 1, 4'b0010, 4'b0000, 1, 1, 0, 0));
        vt.push_back(mk(4, 1, 4'b0011, 4'b0001, 1, 1, 0, 0));
        vt.push_back(mk(4, 1, 4'b0010, 4'b0010, 1, 1, 1, 0));
        vt.push_back(mk(4, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
        // 5: reset in the middle of a port 3 packet
        vt.push_back(mk(5, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(5, 1, 4'b1000, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(5, 1, 4'b1000, 4'b0000, 1, 1, 3, 0));
        vt.push_back(mk(5, 0, 4'b1000, 4'b0000, 1, 1, 3, 0));
        vt.push_back(mk(5, 1, 4'b1001, 4'b0000, 1, 0, 0, 0));
        vt.push_back(mk(5, 1, 4'b1001, 4'b0001, 1, 1, 0, 0));
        vt.push_back(mk(5, 1, 4'b1000, 4'b1000, 1, 1, 3, 0));
        vt.push_back(mk(5, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));

        for (int n = 0; n < vt.size(); n++) begin
            @(negedge aclk);
            aresetn = vt[n].rst_n;
            s_valid = vt[n].vld;
            s_last  = vt[n].last;
            m_ready = vt[n].rdy;
            #1;
            act  = vt[n].lk && vt[n].rst_n;
            id   = vt[n].id;
            e_sr = (act && vt[n].rdy) ? (4'b0001 << id) : 4'b0000;
            chk("m_valid", 64'(m_valid), 64'(act && vt[n].vld[id]), n);
            chk("s_ready", 64'(s_ready), 64'(e_sr), n);
            chk("m_id",    64'(m_id),    act ? 64'(id) : 64'd0, n);
            chk("m_last",  64'(m_last),  64'(act && vt[n].last[id]), n);
            chk("m_data",  m_data,       act ? pd(id) : 64'd0, n);
            chk("m_dest",  64'(m_dest),  64'(act && id[0]), n);
            if (vt[n].hold) chk("m_data_hold", m_data, prev_data, n);
            if (vt[n].tst == 4 && m_valid && m_ready && m_id == 2'd0) hs4++;
            prev_data = m_data;
        end
        chk("t4_beat_count", 64'(hs4), 64'd3, vt.size());

        // 6: no-TLAST variant alternates grants every beat
        @(negedge aclk);
        aresetn = 1'b0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        s_valid = 4'b0101;
        #1;
        chk("nl_idle_valid", 64'(nl_m_valid), 64'd0, 100);
        chk("nl_idle_ready", 64'(nl_s_ready), 64'd0, 100);
        for (int k = 0; k < 6; k++) begin
            @(negedge aclk);
            #1;
            id = (k % 2 == 0) ? 2'd0 : 2'd2;
            chk("nl_m_valid", 64'(nl_m_valid), 64'd1, 101 + k);
            chk("nl_m_id",    64'(nl_m_id),    64'(id), 101 + k);
            chk("nl_m_last",  64'(nl_m_last),  64'd0, 101 + k);
            chk("nl_s_ready", 64'(nl_s_ready), 64'(4'b0001 << id), 101 + k);
            chk("nl_m_data",  nl_m_data,       pd(id), 101 + k);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
